// File: rtl/frog_hit_ctrl.sv
// Collision and lives controller: box-overlap test of the frog against two cars,
// followed by the hit / freeze / respawn / grace / game-over sequence.
module frog_hit_ctrl #(
  parameter int unsigned CAR_HALF_W = 16,
  parameter int unsigned CAR_HALF_H = 8,
  parameter int unsigned FROG_HALF  = 8,
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned HIT_HOLD   = 50000000,
  parameter int unsigned GRACE      = 25000000
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] frogX,
  input  logic [9:0] frogY,
  input  logic [9:0] car0X,
  input  logic [9:0] car0Y,
  input  logic [9:0] car1X,
  input  logic [9:0] car1Y,
  input  logic [1:0] car_en,
  output logic       hit,
  output logic       frog_freeze,
  output logic       frog_respawn,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] dbg_state_o
);

  localparam int CNT_W = 26;
  localparam logic [10:0]      LIM_X     = 11'(FROG_HALF + CAR_HALF_W);
  localparam logic [10:0]      LIM_Y     = 11'(FROG_HALF + CAR_HALF_H);
  localparam logic [CNT_W-1:0] HIT_LAST  = CNT_W'(HIT_HOLD - 1);
  localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE - 1);
  localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);

  typedef enum logic [2:0] {
    ST_ALIVE   = 3'd0,
    ST_HIT     = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_GRACE   = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lives_q, lives_d;
  logic             ovl_q, ovl_d;

  // Absolute difference of two 10-bit coordinates, widened so it cannot wrap.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[10] ? (11'd0 - d) : d;
  endfunction

  logic ovl_car0, ovl_car1;

  always_comb begin
    ovl_car0 = car_en[0] && (abs_diff(frogX, car0X) < LIM_X) && (abs_diff(frogY, car0Y) < LIM_Y);
    ovl_car1 = car_en[1] && (abs_diff(frogX, car1X) < LIM_X) && (abs_diff(frogY, car1Y) < LIM_Y);
    // Overlap is only tracked while ALIVE, so a stale flag never survives GRACE.
    ovl_d    = (ovl_car0 || ovl_car1) && (state_q == ST_ALIVE);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_ALIVE;
      cnt_q   <= '0;
      lives_q <= LIVES_RST;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      ovl_q   <= ovl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    unique case (state_q)
      ST_ALIVE: begin
        if (ovl_q) begin
          state_d = ST_HIT;
          cnt_d   = '0;
          lives_d = lives_q - 2'd1;
        end
      end
      ST_HIT: begin
        if (cnt_q == HIT_LAST) begin
          state_d = (lives_q == 2'd0) ? ST_OVER : ST_RESPAWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESPAWN: begin
        state_d = ST_GRACE;
        cnt_d   = '0;
      end
      ST_GRACE: begin
        if (cnt_q == GRACE_LAST) begin
          state_d = ST_ALIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_ALIVE;
        cnt_d   = '0;
      end
    endcase
  end

  // The hit pulse is the first HIT cycle; the counter is cleared on entry.
  assign hit          = (state_q == ST_HIT) && (cnt_q == '0);
  assign frog_freeze  = (state_q == ST_HIT) || (state_q == ST_OVER);
  assign frog_respawn = (state_q == ST_RESPAWN);
  assign game_over    = (state_q == ST_OVER);
  assign lives        = lives_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_frog_hit_ctrl.sv
// Directed bench for frog_hit_ctrl with short hold/grace timing.
module tb_frog_hit_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic [9:0] frogX, frogY, car0X, car0Y, car1X, car1Y;
  logic [1:0] car_en;
  logic       hit, frog_freeze, frog_respawn, game_over;
  logic [1:0] lives;
  logic [2:0] dbg_state;

  int checks_cnt = 0;
  int errors_cnt = 0;

  frog_hit_ctrl #(
    .CAR_HALF_W(16), .CAR_HALF_H(8), .FROG_HALF(8),
    .LIVES_INIT(3), .HIT_HOLD(4), .GRACE(3)
  ) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .frogX        (frogX),
    .frogY        (frogY),
    .car0X        (car0X),
    .car0Y        (car0Y),
    .car1X        (car1X),
    .car1Y        (car1Y),
    .car_en       (car_en),
    .hit          (hit),
    .frog_freeze  (frog_freeze),
    .frog_respawn (frog_respawn),
    .lives        (lives),
    .game_over    (game_over),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic h, input logic f,
                             input logic r, input logic [1:0] l, input logic g);
    check({tag, ".hit"},     32'(hit),          32'(h));
    check({tag, ".freeze"},  32'(frog_freeze),  32'(f));
    check({tag, ".respawn"}, 32'(frog_respawn), 32'(r));
    check({tag, ".lives"},   32'(lives),        32'(l));
    check({tag, ".over"},    32'(game_over),    32'(g));
  endtask

  task automatic run_expect(input string tag, input int n, input logic h, input logic f,
                            input logic r, input logic [1:0] l, input logic g);
    for (int i = 0; i < n; i++) begin
      step();
      expect_outs(tag, h, f, r, l, g);
    end
  endtask

  task automatic set_pos(input logic [9:0] fx, input logic [9:0] fy,
                         input logic [9:0] c0x, input logic [9:0] c0y,
                         input logic [9:0] c1x, input logic [9:0] c1y);
    frogX = fx; frogY = fy; car0X = c0x; car0Y = c0y; car1X = c1x; car1Y = c1y;
  endtask

  initial begin
    Reset  = 1'b1;
    car_en = 2'b11;
    set_pos(10'd320, 10'd400, 10'd100, 10'd278, 10'd500, 10'd278);
    step();
    step();
    expect_outs("rst_hold", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
    Reset = 1'b0;

    // Frog well clear of both cars.
    run_expect("idle", 8, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);

    // Horizontal distance equal to the limit is not an overlap.
    frogY = 10'd278;
    car0X = 10'd344;
    run_expect("edge_eq", 6, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);

    // One pixel closer overlaps; hit appears two edges later.
    car0X = 10'd343;
    run_expect("edge_lt_d1", 1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
    run_expect("hit1", 1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    frogY = 10'd400;
    run_expect("hit1_hold", 3, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    run_expect("resp1", 1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    run_expect("grace1", 3, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    step();
    check("alive_state", 32'(dbg_state), 32'd0);
    run_expect("alive1", 4, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

    // Persistent overlap, here with both cars at once (one hit each time).
    set_pos(10'd320, 10'd278, 10'd343, 10'd278, 10'd300, 10'd285);
    run_expect("p_d1", 1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    run_expect("hit2", 1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    run_expect("hit2_hold", 3, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
    run_expect("resp2", 1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    run_expect("grace2", 3, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    run_expect("alive2", 2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    run_expect("hit3", 1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    run_expect("hit3_hold", 3, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    run_expect("over", 1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

    // Game over holds regardless of input activity.
    for (int i = 0; i < 6; i++) begin
      set_pos(10'(100 + 37 * i), 10'(278 + i), 10'(100 + 37 * i), 10'd278, 10'd20, 10'(50 * i));
      car_en = 2'(i);
      run_expect("over_hold", 1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    end

    // Collision enable gating.
    Reset  = 1'b1;
    car_en = 2'b00;
    set_pos(10'd320, 10'd278, 10'd343, 10'd278, 10'd500, 10'd278);
    #1;
    expect_outs("rst2", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
    step();
    Reset = 1'b0;
    run_expect("en_off", 5, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
    car_en = 2'b01;
    run_expect("en_on_d1", 1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
    run_expect("en_hit", 1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);

    // Reset in the second HIT cycle aborts with no respawn afterwards.
    run_expect("hit_c2", 1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    Reset = 1'b1;
    frogY = 10'd400;
    #1;
    expect_outs("abort", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
    check("abort_state", 32'(dbg_state), 32'd0);
    step();
    Reset = 1'b0;
    run_expect("post_abort", 8, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/frog_hit_ctrl.md
# frog_hit_ctrl

Collision-and-lives controller sitting directly downstream of the car movers. It consumes the car center positions (X/Y) and the frog center position each clock. It detects box overlap and runs the hit / freeze / respawn / game-over sequence. Its outputs drive the frog mover (freeze, respawn), the score/lives display and the top-level game FSM.

## Interface
- CAR_HALF_W, 16: car half-width in pixels
- CAR_HALF_H, 8: car half-height in pixels
- FROG_HALF, 8: frog half-size in pixels, both axes
- LIVES_INIT, 3: lives after reset (1..3)
- HIT_HOLD, 50000000: cycles the frog stays frozen after a hit (≥1)
- GRACE, 25000000: post-respawn cycles with collisions ignored (≥1)

Ports:
- frame_clk  in  1  clock
- Reset  in  1  reset, asynchronous, active-high
- frogX, frogY  in  10  frog center
- car0X, car0Y, car1X, car1Y  in  10 each  car centers (from car movers)
- car_en  in  2  per-car collision enable; bit i gates car i
- hit  out  1  one-cycle pulse on each counted hit
- frog_freeze  out  1  high while frog must not move
- frog_respawn  out  1  one-cycle pulse; frog mover reloads start position
- lives  out  2  remaining lives
- game_over  out  1  sticky until Reset

## Operation
- Overlap for car i: |frogX−carX| < FROG_HALF+CAR_HALF_W AND |frogY−carY| < FROG_HALF+CAR_HALF_H AND car_en[i].
  - Differences computed as 11-bit signed; no wrap. Equality is no overlap.
- ovl = OR over both cars, registered once (ovl_q).
- FSM states and transitions:
  - ALIVE: if ovl_q → HIT; lives decremented on that edge.
  - HIT: freeze high; counter counts 0..HIT_HOLD−1, then → OVER if lives==0, else → RESPAWN.
  - RESPAWN: one cycle; frog_respawn high; → GRACE.
  - GRACE: freeze low; ovl_q ignored; counter 0..GRACE−1, then → ALIVE.
  - OVER: game_over=1, frog_freeze=1; absorbing until Reset.
- Counter is shared by HIT and GRACE and cleared on every state entry. Width: 26 bits, enough for the defaults.
- lives never underflows: it is decremented only in ALIVE→HIT, and that transition cannot occur with lives==0 since OVER absorbs.
- Reset values: state=ALIVE, lives=LIVES_INIT, counter=0, ovl_q=0, hit=0, frog_freeze=0, frog_respawn=0, game_over=0.
- Reset mid-HIT or mid-GRACE aborts immediately to reset values; no respawn pulse is produced.

## Timing
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- Latency:
  - Overlap present in the inputs sampled at edge n sets ovl_q after edge n.
  - FSM enters HIT after edge n+1.
  - hit=1 and frog_freeze=1 in the cycle following edge n+1; lives shows the decremented value in the same cycle.
- hit: exactly one cycle per ALIVE→HIT transition, even if overlap persists.
- HIT lasts exactly HIT_HOLD cycles. RESPAWN lasts exactly 1 cycle. GRACE lasts exactly GRACE cycles.
- Continuous overlap through GRACE causes a new hit 2 cycles after GRACE ends, via ovl_q in ALIVE.
- Simultaneous overlap with both cars counts as one hit.
- Input changes during HIT, RESPAWN, GRACE or OVER have no effect except through ovl_q in ALIVE.

## Test plan
Benches use HIT_HOLD=4, GRACE=3, LIVES_INIT=3.
- Reset, frog (320,400), cars (100,278) and (500,278), car_en=11 → hit never pulses; lives=3; all other outputs 0 indefinitely.
- Boundary overlap: frog (320,278), car0X=344 → no hit. car0X=343 → hit 2 cycles later; lives=2.
- Single hit, then frog moved clear → freeze high exactly 4 cycles, then respawn pulse for 1 cycle, then 3 cycles of grace, then ALIVE with lives=2.
- Persistent overlap through the whole sequence:
  - Three hits total, each separated by 4+1+3+2 cycles.
  - On the third hit, lives=0; after 4 freeze cycles the FSM enters OVER with game_over=1 and no respawn pulse.
  - game_over stays high while inputs keep changing.
- car_en=00 with frog on car0 → no hit. Setting car_en=01 → hit 2 cycles later.
- Assert Reset during the 2nd HIT cycle → outputs return to reset values immediately with lives=3. After release with frog clear, no respawn or hit pulse occurs.
